// File: rtl/chattering_cut.sv
// Push-switch debouncer: two-flop synchroniser, DIV-cycle sample tick, and an output
// that flips only after STABLE_SAMPLES consecutive differing ticks. Optional edge pulses via CHATTERING_CUT_EDGE_EN.
module chattering_cut #(
    parameter int   DIV            = 32000,
    parameter int   STABLE_SAMPLES = 2,
    parameter logic RESET_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_out
`ifdef CHATTERING_CUT_EDGE_EN
    ,
    output logic sw_rise,
    output logic sw_fall
`endif
);

    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [3:0]    CNT_LAST  = 4'(STABLE_SAMPLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    stable_cnt_q, stable_cnt_d;
    logic          sw_out_q, sw_out_d;
    logic          tick;

    always_comb begin
        s1_d         = sw_in;
        s2_d         = s1_q;
        tick         = (tick_cnt_q == TICK_LAST);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + CW'(1);
        stable_cnt_d = stable_cnt_q;
        sw_out_d     = sw_out_q;
        // Any tick that agrees with the output restarts the run of differing samples.
        if (tick) begin
            if (s2_q == sw_out_q) begin
                stable_cnt_d = '0;
            end else if (stable_cnt_q == CNT_LAST) begin
                sw_out_d     = s2_q;
                stable_cnt_d = '0;
            end else begin
                stable_cnt_d = stable_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= RESET_VAL;
            s2_q         <= RESET_VAL;
            tick_cnt_q   <= '0;
            stable_cnt_q <= '0;
            sw_out_q     <= RESET_VAL;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            tick_cnt_q   <= tick_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            sw_out_q     <= sw_out_d;
        end
    end

    assign sw_out = sw_out_q;

`ifdef CHATTERING_CUT_EDGE_EN
    logic sw_rise_q, sw_rise_d;
    logic sw_fall_q, sw_fall_d;

    // Pulses land on the same edge that updates sw_out.
    always_comb begin
        sw_rise_d = sw_out_d & ~sw_out_q;
        sw_fall_d = ~sw_out_d & sw_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_rise_q <= 1'b0;
            sw_fall_q <= 1'b0;
        end else begin
            sw_rise_q <= sw_rise_d;
            sw_fall_q <= sw_fall_d;
        end
    end

    assign sw_rise = sw_rise_q;
    assign sw_fall = sw_fall_q;
`endif

endmodule

// File: tb/tb_chattering_cut.sv
// Directed bench: a scaled debouncer (DIV=16, 2 samples) and a plain sampler (DIV=4, 1 sample, reset value 1).
module tb_chattering_cut;

    logic clk;
    logic rst, rst_b;
    logic sw_in_a, sw_in_b;
    logic sw_out_a, sw_out_b;
`ifdef CHATTERING_CUT_EDGE_EN
    logic sw_rise_a, sw_fall_a, sw_rise_b, sw_fall_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int tog_a  = 0;
    int rise_a = 0;
    int fall_a = 0;
    int edge_bad = 0;
    logic prev_a = 1'b0;

    chattering_cut #(.DIV(16), .STABLE_SAMPLES(2), .RESET_VAL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .sw_in(sw_in_a), .sw_out(sw_out_a)
`ifdef CHATTERING_CUT_EDGE_EN
        , .sw_rise(sw_rise_a), .sw_fall(sw_fall_a)
`endif
    );

    chattering_cut #(.DIV(4), .STABLE_SAMPLES(1), .RESET_VAL(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .sw_in(sw_in_b), .sw_out(sw_out_b)
`ifdef CHATTERING_CUT_EDGE_EN
        , .sw_rise(sw_rise_b), .sw_fall(sw_fall_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output activity monitor for dut_a, sampled away from the active edge.
    always @(negedge clk) begin
        if (sw_out_a !== prev_a) tog_a++;
`ifdef CHATTERING_CUT_EDGE_EN
        if (sw_rise_a === 1'b1) rise_a++;
        if (sw_fall_a === 1'b1) fall_a++;
        if (sw_rise_a !== (prev_a === 1'b0 && sw_out_a === 1'b1)) edge_bad++;
        if (sw_fall_a !== (prev_a === 1'b1 && sw_out_a === 1'b0)) edge_bad++;
`endif
        prev_a = sw_out_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rst_b = 1'b0;
        sw_in_a = 1'b1; sw_in_b = 1'b0;
        #1;
        rst = 1'b1; rst_b = 1'b1;
        cyc(3);
        chk("reset_a", 32'(sw_out_a), 0);
        chk("reset_b", 32'(sw_out_b), 1);

        // First rise lands on the second tick: edge 32 after release.
        rst = 1'b0;
        cyc(31);
        chk("pre_first_rise", 32'(sw_out_a), 0);
        chk("no_early_toggle", 32'(tog_a), 0);
        cyc(1);
        chk("first_rise", 32'(sw_out_a), 1);

        // Bounce shorter than one tick period, ending high.
        sw_in_a = 1'b0; cyc(3);
        sw_in_a = 1'b1; cyc(3);
        sw_in_a = 1'b0; cyc(3);
        sw_in_a = 1'b1; cyc(3);
        cyc(40);
        chk("bounce_hold", 32'(sw_out_a), 1);
        chk("bounce_tog", 32'(tog_a), 1);

        // Clean fall: not before edge 19, done by edge 34.
        sw_in_a = 1'b0;
        cyc(18);
        chk("fall_not_early", 32'(sw_out_a), 1);
        cyc(16);
        chk("fall_in_time", 32'(sw_out_a), 0);
        chk("fall_tog", 32'(tog_a), 2);
        cyc(66);
        chk("fall_hold", 32'(sw_out_a), 0);
        chk("fall_once", 32'(tog_a), 2);
`ifdef CHATTERING_CUT_EDGE_EN
        chk("fall_pulses", 32'(fall_a), 1);
`endif

        // Bounce then held high: exactly one rise.
        sw_in_a = 1'b1; cyc(3);
        sw_in_a = 1'b0; cyc(3);
        sw_in_a = 1'b1;
        cyc(100);
        chk("rise_hold", 32'(sw_out_a), 1);
        chk("rise_once", 32'(tog_a), 3);
`ifdef CHATTERING_CUT_EDGE_EN
        chk("rise_pulses", 32'(rise_a), 2);
        chk("fall_pulses_end", 32'(fall_a), 1);
        chk("edge_coincident", 32'(edge_bad), 0);
`endif

        // Plain sampler: output takes s2 at every 4th edge.
        rst_b = 1'b0;
        cyc(3);
        chk("b_pre_tick1", 32'(sw_out_b), 1);
        cyc(1);
        chk("b_tick1", 32'(sw_out_b), 0);
        sw_in_b = 1'b1;
        cyc(3);
        chk("b_pre_tick2", 32'(sw_out_b), 0);
        cyc(1);
        chk("b_tick2", 32'(sw_out_b), 1);
        sw_in_b = 1'b0;
        cyc(2);
        sw_in_b = 1'b1;
        cyc(1);
        chk("b_pre_tick3", 32'(sw_out_b), 1);
        cyc(1);
        chk("b_tick3_glitch", 32'(sw_out_b), 0);
        cyc(4);
        chk("b_tick4", 32'(sw_out_b), 1);
        sw_in_b = 1'b0;
        cyc(4);
        chk("b_tick5", 32'(sw_out_b), 0);

        // Reset mid-count acts without a clock edge.
        cyc(1);
        #2;
        rst_b = 1'b1;
        #1;
        chk("b_async_reset", 32'(sw_out_b), 1);
        cyc(1);
        chk("b_reset_hold", 32'(sw_out_b), 1);
        rst_b = 1'b0;
        cyc(3);
        chk("b_restart_pre", 32'(sw_out_b), 1);
        cyc(1);
        chk("b_restart_tick", 32'(sw_out_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
